// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock,
// built from a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             bw;
  logic [CNT_W-1:0] cnt;

  logic ai;
  logic bi;
  logic d;
  logic bw_nxt;

  // Full-subtractor cell on the current LSBs and the stored borrow
  always_comb begin
    ai     = a_sh[0];
    bi     = b_sh[0];
    d      = ai ^ bi ^ bw;
    bw_nxt = (~ai & bi) | (~(ai ^ bi) & bw);
  end

  // Control FSM, operand shifters, result shifter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bw    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res  <= {d, res[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bw   <= bw_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done       <= 1'b1;
          diff       <= res;
          borrow_out <= bw;
          state      <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, bo8;

  logic       start4;
  logic [3:0] a4, b4, diff4;
  logic       busy4, done4, bo4;

  int vecs  = 0;
  int fails = 0;
  int done8_cnt = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    if (done8 === 1'b1) done8_cnt++;
  endtask

  // Full WIDTH=8 operation with latency, busy-length and pulse-width checks
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input string tag);
    int busy_n = 0;
    int lat = 99;
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    if (busy8 === 1'b1) busy_n++;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done8 === 1'b1) begin
        lat = k;
        break;
      end
      if (busy8 === 1'b1) busy_n++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_busy"}, 32'(busy_n), 32'd8);
    chk({tag, "_diff"}, 32'(diff8), 32'(ed));
    chk({tag, "_bo"}, 32'(bo8), 32'(eb));
    tick();
    chk({tag, "_pulse"}, 32'(done8), 32'd0);
  endtask

  // WIDTH=4 operation, next start issued right after done
  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] full;
    bit seen = 0;
    full = {1'b0, a} - {1'b0, b};
    a4 = a; b4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done4 === 1'b1) begin
        seen = 1;
        break;
      end
    end
    chk("w4_done", 32'(seen), 32'd1);
    chk("w4_diff", 32'(diff4), 32'(full[3:0]));
    chk("w4_bo", 32'(bo4), 32'(a < b));
  endtask

  initial begin
    int snap;
    int busy_n;
    rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bo", 32'(bo8), 32'd0);
    rst = 1'b0;
    tick();

    // Basic and underflow cases
    op8(8'h05, 8'h03, 8'h02, 1'b0, "t1");
    op8(8'h03, 8'h05, 8'hFE, 1'b1, "t2a");
    op8(8'hFF, 8'h01, 8'hFE, 1'b0, "t2b");
    // Boundaries
    op8(8'h00, 8'h00, 8'h00, 1'b0, "t3a");
    op8(8'h00, 8'hFF, 8'h01, 1'b1, "t3b");
    op8(8'h80, 8'h01, 8'h7F, 1'b0, "t3c");

    // Start mid-RUN with new operands is ignored
    snap = done8_cnt;
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t4a_done", 32'(done8), 32'd1);
    chk("t4a_diff", 32'(diff8), 32'h0F);
    chk("t4a_bo", 32'(bo8), 32'd0);

    // Start during the DONE cycle is ignored
    a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    a8 = 8'hAA; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("t4b_done", 32'(done8), 32'd1);
    chk("t4b_diff", 32'(diff8), 32'h1F);
    busy_n = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (busy8 === 1'b1) busy_n++;
    end
    chk("t4b_nobusy", 32'(busy_n), 32'd0);
    chk("t4_pulses", 32'(done8_cnt - snap), 32'd2);

    // Reset while processing bit 4 aborts the operation
    snap = done8_cnt;
    a8 = 8'hC3; b8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(busy8), 32'd0);
    chk("t5_diff", 32'(diff8), 32'd0);
    chk("t5_bo", 32'(bo8), 32'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("t5_nodone", 32'(done8_cnt - snap), 32'd0);
    op8(8'h9C, 8'h3A, 8'h62, 1'b0, "t5c");
    op8(8'h3A, 8'h9C, 8'h9E, 1'b1, "t5d");

    // WIDTH=4 exhaustive, back to back
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op4(4'(i), 4'(j));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
